miter_stim_driver: RTL and testbench

- Sequential stimulus driver and response checker for the other end of an equivalence miter.
- Generates pseudo-random primary-input vectors for a gold/gate pair and captures both output buses after a fixed latency.
- Compares the captured outputs bitwise under a per-bit don't-care mask, then reports pass/fail, mismatch count and first failing vector index.
- Sits in the simulation/formal bench around the gold and gate instances.

---
 rtl/miter_pkg.sv | 24 ++
 rtl/miter_lfsr32.sv | 38 +++
 rtl/miter_stim_driver.sv | 179 +++++++++++++++++
 tb/tb_miter_stim_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/miter_pkg.sv
// miter_pkg: shared types, constants and LFSR helpers for the miter stimulus driver.
// The seed fix-up keeps an all-zero seed from locking the LFSR.
package miter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } miter_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int          CNT_W     = 16;
  localparam logic [CNT_W-1:0] IDX_NONE = 16'hFFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/miter_lfsr32.sv
// miter_lfsr32: 32-bit right-shifting Galois LFSR with synchronous seed load and step enable.
// Only the low OUT_W state bits are exported so narrow consumers leave no dangling bits.
module miter_lfsr32
  import miter_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      seed_i,
  output logic [OUT_W-1:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_fix(seed_i);
    end else if (step_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed_fix(seed_i);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/miter_stim_driver.sv
// miter_stim_driver: LFSR stimulus driver and masked gold/gate response checker for a miter.
// Optional MITER_STOP_ON_FAIL_EN: end the run on the cycle after the first mismatching compare.
module miter_stim_driver
  import miter_pkg::*;
#(
  parameter int          PI_WIDTH = 1,
  parameter int          PO_WIDTH = 1,
  parameter int          NUM_VEC  = 256,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] SEED     = 32'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PI_WIDTH-1:0] pi,
  output logic                pi_valid,
  input  logic [PO_WIDTH-1:0] out_gold,
  input  logic [PO_WIDTH-1:0] out_gate,
  input  logic [PO_WIDTH-1:0] dc_mask,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic [CNT_W-1:0]    first_fail_idx
);

  localparam logic [31:0]      SEED_EFF   = seed_fix(SEED);
  localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(NUM_VEC - 1);
  localparam logic [2:0]       DRAIN_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  miter_state_e        state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [2:0]          drain_q, drain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    ffi_q, ffi_d;
  logic [PI_WIDTH-1:0] pi_hold_q, pi_hold_d;

  logic                lfsr_load;
  logic                lfsr_step_en;
  logic [PI_WIDTH-1:0] lfsr_bits;

  logic                cmp_valid;
  logic [CNT_W-1:0]    cmp_idx;
  logic                cmp_fire;
  logic                mismatch;
  logic                flush;

  miter_lfsr32 #(
    .OUT_W (PI_WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step_en),
    .seed_i  (SEED_EFF),
    .state_o (lfsr_bits)
  );

  // Compare pipeline: the issue-cycle valid and index travel alongside the DUT latency.
  generate
    if (LATENCY == 0) begin : g_lat0
      assign cmp_valid = pi_valid;
      assign cmp_idx   = idx_q;
    end else begin : g_latn
      logic [LATENCY-1:0] vld_sr_q;
      logic [CNT_W-1:0]   idx_sr_q [LATENCY];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld_sr_q <= '0;
        end else begin
          vld_sr_q <= (vld_sr_q << 1) | LATENCY'(pi_valid);
        end
      end

      always_ff @(posedge clk) begin
        for (int k = LATENCY - 1; k > 0; k--) begin
          idx_sr_q[k] <= idx_sr_q[k-1];
        end
        idx_sr_q[0] <= idx_q;
      end

      assign cmp_valid = vld_sr_q[LATENCY-1];
      assign cmp_idx   = idx_sr_q[LATENCY-1];
    end
  endgenerate

  assign cmp_fire = cmp_valid && ((state_q == RUN) || (state_q == DRAIN));
  assign mismatch = |((out_gold ^ out_gate) & ~dc_mask);
  // Anything still in flight when a run ends belongs to a finished or aborted run.
  assign flush    = (state_d == DONE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    ffi_d        = ffi_q;
    pi_hold_d    = pi_hold_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;

    if (cmp_fire && mismatch) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (ffi_q == IDX_NONE) begin
        ffi_d = cmp_idx;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          idx_d     = '0;
          drain_d   = '0;
          cnt_d     = '0;
          ffi_d     = IDX_NONE;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        lfsr_step_en = 1'b1;
        pi_hold_d    = lfsr_bits;
        idx_d        = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = (LATENCY == 0) ? DONE : DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MITER_STOP_ON_FAIL_EN
    if (cmp_fire && mismatch) begin
      state_d = DONE;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      drain_q   <= '0;
      cnt_q     <= '0;
      ffi_q     <= IDX_NONE;
      pi_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      ffi_q     <= ffi_d;
      pi_hold_q <= pi_hold_d;
    end
  end

  // While running, pi follows the generator directly; otherwise it holds the last vector issued.
  assign pi             = (state_q == RUN) ? lfsr_bits : pi_hold_q;
  assign pi_valid       = (state_q == RUN);
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (cnt_q == '0);
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_miter_stim_driver.sv
// tb_miter_stim_driver: two driver instances (LATENCY=1/NUM_VEC=16 and LATENCY=0/NUM_VEC=1)
// against gold/gate peers with injected faults; expectations come from per-vector fault tables.
module tb_miter_stim_driver;

  localparam int          PI_W  = 8;
  localparam int          PO_W  = 8;
  localparam int          NV    = 16;
  localparam logic [31:0] SEED1 = 32'h0000ACE1;
`ifdef MITER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start0 = 1'b0;
  always #5 clk = ~clk;

  logic [PI_W-1:0] pi;
  logic            pi_valid, busy, done, pass;
  logic [PO_W-1:0] gold_q, gate_q, dc_q;
  logic [15:0]     mcnt, ffi;
  logic [PO_W-1:0] err_arr [NV];
  logic [PO_W-1:0] dc_arr  [NV];
  int              vi_q;

  logic [4:0]  pi0;
  logic        pi_valid0, busy0, done0, pass0;
  logic [3:0]  gold0, gate0, err0, dc0;
  logic [15:0] mcnt0, ffi0;

  int n_chk = 0;
  int n_fail = 0;

  miter_stim_driver #(
    .PI_WIDTH (PI_W), .PO_WIDTH (PO_W), .NUM_VEC (NV), .LATENCY (1), .SEED (SEED1)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start), .pi (pi), .pi_valid (pi_valid),
    .out_gold (gold_q), .out_gate (gate_q), .dc_mask (dc_q),
    .busy (busy), .done (done), .pass (pass),
    .mismatch_cnt (mcnt), .first_fail_idx (ffi)
  );

  miter_stim_driver #(
    .PI_WIDTH (5), .PO_WIDTH (4), .NUM_VEC (1), .LATENCY (0), .SEED (32'h0)
  ) u_dut0 (
    .clk (clk), .rst (rst), .start (start0), .pi (pi0), .pi_valid (pi_valid0),
    .out_gold (gold0), .out_gate (gate0), .dc_mask (dc0),
    .busy (busy0), .done (done0), .pass (pass0),
    .mismatch_cnt (mcnt0), .first_fail_idx (ffi0)
  );

  // One-cycle gold/gate peers; the gate copy carries the fault pattern of the current vector.
  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      vi_q <= 0;
    end else if (pi_valid) begin
      gold_q <= {pi[3:0], pi[7:4]} ^ 8'h3C;
      gate_q <= ({pi[3:0], pi[7:4]} ^ 8'h3C) ^ err_arr[vi_q % NV];
      dc_q   <= dc_arr[vi_q % NV];
      vi_q   <= vi_q + 1;
    end
  end

  assign gold0 = pi0[3:0] ^ {pi0[4], 3'b000};
  assign gate0 = gold0 ^ err0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic run1(input string name, input int exp_busy, input int exp_vecs,
                      input logic exp_pass, input logic [15:0] exp_cnt,
                      input logic [15:0] exp_ffi, input bit poke);
    logic [31:0]     m;
    logic [PI_W-1:0] last_pi;
    int              nbusy, nvec, bad_pi;
    m = SEED1; last_pi = '0; nbusy = 0; nvec = 0; bad_pi = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (busy && nbusy < 200) begin
      nbusy++;
      if (pi_valid) begin
        if (pi !== m[PI_W-1:0]) bad_pi++;
        last_pi = m[PI_W-1:0];
        m = lfsr_next(m);
        nvec++;
        if (poke && nvec == 5) start = 1'b1;
      end
      @(negedge clk) start = 1'b0;
    end
    chk({name, ".busy_cycles"}, nbusy, exp_busy);
    chk({name, ".vectors"}, nvec, exp_vecs);
    chk({name, ".pi_seq_errors"}, bad_pi, 0);
    chk({name, ".done"}, done, 1'b1);
    chk({name, ".pi_valid"}, pi_valid, 1'b0);
    chk({name, ".pi_hold"}, pi, last_pi);
    chk({name, ".pass"}, pass, exp_pass);
    chk({name, ".mismatch_cnt"}, mcnt, exp_cnt);
    chk({name, ".first_fail_idx"}, ffi, exp_ffi);
    $display("run %s: busy=%0d vecs=%0d pass=%0b cnt=%0d ffi=%0h", name, nbusy, nvec, pass, mcnt, ffi);
  endtask

  task automatic run0(input string name, input logic [3:0] e, input logic [3:0] d,
                      input logic exp_pass, input logic [15:0] exp_cnt, input logic [15:0] exp_ffi);
    err0 = e; dc0 = d;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk({name, ".run_done"}, done0, 1'b0);
    chk({name, ".run_busy"}, busy0, 1'b1);
    chk({name, ".run_pi_valid"}, pi_valid0, 1'b1);
    chk({name, ".run_pi"}, pi0, 5'd1);
    @(negedge clk);
    chk({name, ".done"}, done0, 1'b1);
    chk({name, ".pi_valid"}, pi_valid0, 1'b0);
    chk({name, ".pi_hold"}, pi0, 5'd1);
    chk({name, ".pass"}, pass0, exp_pass);
    chk({name, ".mismatch_cnt"}, mcnt0, exp_cnt);
    chk({name, ".first_fail_idx"}, ffi0, exp_ffi);
    $display("run %s: pass=%0b cnt=%0d ffi=%0h", name, pass0, mcnt0, ffi0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".pi"}, pi, '0);
    chk({name, ".pi_valid"}, pi_valid, 1'b0);
    chk({name, ".busy"}, busy, 1'b0);
    chk({name, ".done"}, done, 1'b0);
    chk({name, ".pass"}, pass, 1'b0);
    chk({name, ".mismatch_cnt"}, mcnt, 16'd0);
    chk({name, ".first_fail_idx"}, ffi, 16'hFFFF);
  endtask

  typedef struct {
    logic [15:0] faults;
    logic [7:0]  dc;
    int          exp_busy;
    int          exp_vecs;
    logic        exp_pass;
    logic [15:0] exp_cnt;
    logic [15:0] exp_ffi;
    bit          poke;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int          cnt, first, rb, rv;
    logic [7:0]  e;

    tbl[0] = '{16'h0000, 8'h00, 17, 16, 1'b1, 16'd0, 16'hFFFF, 1'b1};
    tbl[1] = '{16'h0020, 8'h00, STOP ? 7 : 17, STOP ? 7 : 16, 1'b0, 16'd1, 16'd5, 1'b0};
    tbl[2] = '{16'h0020, 8'hFF, 17, 16, 1'b1, 16'd0, 16'hFFFF, 1'b0};
    tbl[3] = '{16'h0088, 8'h00, STOP ? 5 : 17, STOP ? 5 : 16, 1'b0, STOP ? 16'd1 : 16'd2, 16'd3, 1'b0};
    tbl[4] = '{16'h8001, 8'h00, STOP ? 2 : 17, STOP ? 2 : 16, 1'b0, STOP ? 16'd1 : 16'd2, 16'd0, 1'b0};
    tbl[5] = '{16'h8000, 8'h0F, 17, 16, 1'b0, 16'd1, 16'd15, 1'b0};
    tbl[6] = '{16'hFFFF, 8'h00, STOP ? 2 : 17, STOP ? 2 : 16, 1'b0, STOP ? 16'd1 : 16'd16, 16'd0, 1'b0};

    err0 = '0; dc0 = '0;
    for (int i = 0; i < NV; i++) begin err_arr[i] = '0; dc_arr[i] = '0; end

    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk("reset.dut0_pi", pi0, 5'd0);
    chk("reset.dut0_ffi", ffi0, 16'hFFFF);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NV; i++) begin
        err_arr[i] = tbl[t].faults[i] ? 8'hFF : 8'h00;
        dc_arr[i]  = tbl[t].dc;
      end
      run1($sformatf("tbl%0d", t), tbl[t].exp_busy, tbl[t].exp_vecs, tbl[t].exp_pass,
           tbl[t].exp_cnt, tbl[t].exp_ffi, tbl[t].poke);
    end

    for (int r = 0; r < 24; r++) begin
      cnt = 0; first = 16'hFFFF;
      for (int i = 0; i < NV; i++) begin
        e = 8'($urandom_range(1, 255));
        err_arr[i] = ($urandom_range(0, 3) == 0) ? e : 8'h00;
        dc_arr[i]  = 8'($urandom) & 8'($urandom);
        if ((err_arr[i] & ~dc_arr[i]) != 8'h00) begin
          cnt++;
          if (first == 16'hFFFF) first = i;
        end
      end
      rb = 17; rv = 16;
      if (STOP && cnt > 0) begin
        cnt = 1;
        rb = (first + 2 < 17) ? first + 2 : 17;
        rv = (first + 2 < 16) ? first + 2 : 16;
      end
      run1($sformatf("rnd%0d", r), rb, rv, cnt == 0, 16'(cnt), 16'(first), (r % 3) == 0);
    end

    // Abort at vector 8 with vector 7 faulted and still in the compare pipeline.
    for (int i = 0; i < NV; i++) begin err_arr[i] = '0; dc_arr[i] = '0; end
    err_arr[7] = 8'hFF;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort.pi_valid_at_vec8", pi_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_reset("abort");
    err_arr[7] = 8'h00;
    run1("after_abort", 17, 16, 1'b1, 16'd0, 16'hFFFF, 1'b0);

    run0("lat0_a", 4'h0, 4'h0, 1'b1, 16'd0, 16'hFFFF);
    run0("lat0_b", 4'h3, 4'h1, 1'b0, 16'd1, 16'd0);
    run0("lat0_c", 4'h3, 4'h3, 1'b1, 16'd0, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
